// File: rtl/czono_loader_if.sv
// czono_loader_if: ready/valid word stream that feeds one constrained zonotope
// (header, c, G, A, b[, checksum]) into czono_loader.
//   s_data  : stream word, DATA_WIDTH bits
//   s_valid : source has a word on s_data
//   s_ready : loader accepts the word this cycle
// Modports: master = stream source, slave = loader.
interface czono_loader_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_valid;
  logic                  s_ready;

  modport master (output s_data, output s_valid, input  s_ready);
  modport slave  (input  s_data, input  s_valid, output s_ready);
endinterface

// File: rtl/czono_loader.sv
// czono_loader: receives one constrained zonotope as a word stream and writes
// it into the c / G / A / b block RAMs read by the plus, linear_image and
// intersection operators. Publishes n / ng / nc and a valid level used as the
// downstream start qualifier.
//
// Ports:
//   clk_i, rstn_i (async, active-low), start (one-cycle pulse, arms a load)
//   s          : czono_loader_if.slave stream (s_data, s_valid, s_ready)
//   n, ng, nc  : loaded dimension / generator count / constraint count
//   c_*, G_*, A_*, b_* : registered RAM write ports (1-cycle we pulses)
//   valid      : all RAMs hold a complete zonotope
//   err        : header out of range (or checksum mismatch)
//
// Optional build macro CZONO_LOADER_CHECKSUM_EN: adds a CHK state that takes
// one trailing word which must equal the XOR of the header and all payload.
module czono_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int NMAX       = 10,
  parameter int NGMAX      = 5,
  parameter int NCMAX      = 3
) (
  input  logic                         clk_i,
  input  logic                         rstn_i,
  input  logic                         start,
  czono_loader_if.slave                s,
  output logic [$clog2(NMAX+1)-1:0]    n,
  output logic [$clog2(NGMAX+1)-1:0]   ng,
  output logic [$clog2(NCMAX+1)-1:0]   nc,
  output logic                         c_we,
  output logic [$clog2(NMAX)-1:0]      c_addr,
  output logic [DATA_WIDTH-1:0]        c_wdata,
  output logic                         G_we,
  output logic [$clog2(NMAX)-1:0]      G_raddr,
  output logic [$clog2(NGMAX)-1:0]     G_caddr,
  output logic [DATA_WIDTH-1:0]        G_wdata,
  output logic                         A_we,
  output logic [$clog2(NCMAX)-1:0]     A_raddr,
  output logic [$clog2(NGMAX)-1:0]     A_caddr,
  output logic [DATA_WIDTH-1:0]        A_wdata,
  output logic                         b_we,
  output logic [$clog2(NCMAX)-1:0]     b_addr,
  output logic [DATA_WIDTH-1:0]        b_wdata,
  output logic                         valid,
  output logic                         err
);
  localparam int NW = $clog2(NMAX+1);
  localparam int GW = $clog2(NGMAX+1);
  localparam int CW = $clog2(NCMAX+1);
  localparam int RA = $clog2(NMAX);
  localparam int GA = $clog2(NGMAX);
  localparam int CA = $clog2(NCMAX);
  localparam logic [7:0] NMAX8  = 8'(NMAX);
  localparam logic [7:0] NGMAX8 = 8'(NGMAX);
  localparam logic [7:0] NCMAX8 = 8'(NCMAX);

  typedef enum logic [3:0] {
    IDLE, HDR, LD_C, LD_G, LD_A, LD_B,
`ifdef CZONO_LOADER_CHECKSUM_EN
    CHK,
`endif
    DONE, ERR
  } state_t;

`ifdef CZONO_LOADER_CHECKSUM_EN
  localparam state_t FIN = CHK;
`else
  localparam state_t FIN = DONE;
`endif

  state_t     state_q, state_d;
  logic [7:0] row_q, col_q;
  logic       ready, xfer;
  logic       last_n, last_nc, last_col, hdr_ok;
  logic [7:0] hdr_n, hdr_ng, hdr_nc;

  assign hdr_n  = s.s_data[7:0];
  assign hdr_ng = s.s_data[15:8];
  assign hdr_nc = s.s_data[23:16];
  assign hdr_ok = (hdr_n  != 8'd0) && (hdr_n  <= NMAX8) &&
                  (hdr_ng != 8'd0) && (hdr_ng <= NGMAX8) &&
                  (hdr_nc <= NCMAX8);

  // Row/column walk end markers against the registered header fields.
  assign last_n   = (row_q == 8'(n)  - 8'd1);
  assign last_nc  = (row_q == 8'(nc) - 8'd1);
  assign last_col = (col_q == 8'(ng) - 8'd1);

  assign s.s_ready = ready;
  assign xfer      = s.s_valid && ready;

`ifdef CZONO_LOADER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] xacc_q;
  logic                  ck_ok;
  assign ck_ok = (s.s_data == xacc_q);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)         xacc_q <= '0;
    else if (xfer) begin
      if (state_q == HDR) xacc_q <= s.s_data;
      else                xacc_q <= xacc_q ^ s.s_data;
    end
  end
`endif

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    case (state_q)
      IDLE, DONE, ERR: if (start) state_d = HDR;
      HDR: begin
        ready = 1'b1;
        if (s.s_valid) state_d = hdr_ok ? LD_C : ERR;
      end
      LD_C: begin
        ready = 1'b1;
        if (s.s_valid && last_n) state_d = LD_G;
      end
      LD_G: begin
        ready = 1'b1;
        if (s.s_valid && last_n && last_col) state_d = (nc == '0) ? FIN : LD_A;
      end
      LD_A: begin
        ready = 1'b1;
        if (s.s_valid && last_nc && last_col) state_d = LD_B;
      end
      LD_B: begin
        ready = 1'b1;
        if (s.s_valid && last_nc) state_d = FIN;
      end
`ifdef CZONO_LOADER_CHECKSUM_EN
      CHK: begin
        ready = 1'b1;
        if (s.s_valid) state_d = ck_ok ? DONE : ERR;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // Write stage: accepted word -> registered RAM write port, one cycle later.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      row_q <= '0; col_q <= '0;
      n <= '0; ng <= '0; nc <= '0;
      valid <= 1'b0; err <= 1'b0;
      c_we <= 1'b0; c_addr <= '0; c_wdata <= '0;
      G_we <= 1'b0; G_raddr <= '0; G_caddr <= '0; G_wdata <= '0;
      A_we <= 1'b0; A_raddr <= '0; A_caddr <= '0; A_wdata <= '0;
      b_we <= 1'b0; b_addr <= '0; b_wdata <= '0;
    end else begin
      c_we <= 1'b0; G_we <= 1'b0; A_we <= 1'b0; b_we <= 1'b0;
      if ((state_q == IDLE || state_q == DONE || state_q == ERR) && start) begin
        valid <= 1'b0;
        err   <= 1'b0;
      end else if (state_q == DONE) begin
        valid <= 1'b1;
      end
      if (xfer) begin
        case (state_q)
          HDR: begin
            row_q <= '0;
            col_q <= '0;
            if (hdr_ok) begin
              n  <= hdr_n[NW-1:0];
              ng <= hdr_ng[GW-1:0];
              nc <= hdr_nc[CW-1:0];
            end else begin
              err <= 1'b1;
            end
          end
          LD_C: begin
            c_we    <= 1'b1;
            c_addr  <= row_q[RA-1:0];
            c_wdata <= s.s_data;
            row_q   <= last_n ? 8'd0 : row_q + 8'd1;
          end
          LD_G: begin
            G_we    <= 1'b1;
            G_raddr <= row_q[RA-1:0];
            G_caddr <= col_q[GA-1:0];
            G_wdata <= s.s_data;
            if (last_col) begin
              col_q <= '0;
              row_q <= last_n ? 8'd0 : row_q + 8'd1;
            end else begin
              col_q <= col_q + 8'd1;
            end
          end
          LD_A: begin
            A_we    <= 1'b1;
            A_raddr <= row_q[CA-1:0];
            A_caddr <= col_q[GA-1:0];
            A_wdata <= s.s_data;
            if (last_col) begin
              col_q <= '0;
              row_q <= last_nc ? 8'd0 : row_q + 8'd1;
            end else begin
              col_q <= col_q + 8'd1;
            end
          end
          LD_B: begin
            b_we    <= 1'b1;
            b_addr  <= row_q[CA-1:0];
            b_wdata <= s.s_data;
            row_q   <= last_nc ? 8'd0 : row_q + 8'd1;
          end
`ifdef CZONO_LOADER_CHECKSUM_EN
          CHK: if (!ck_ok) err <= 1'b1;
`endif
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_czono_loader.sv
// tb_czono_loader: directed-vector bench for czono_loader. A monitor captures
// every RAM write pulse into shadow arrays; directed loads are then compared
// against hand-written expected contents, counts and cycle offsets.
module tb_czono_loader;
`ifdef CZONO_LOADER_CHECKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif

  logic clk_tb = 1'b0;
  logic rstn   = 1'b1;
  logic start  = 1'b0;
  always #5 clk_tb = ~clk_tb;

  czono_loader_if #(.DATA_WIDTH(32)) s_if ();

  logic [3:0]  n;
  logic [2:0]  ng;
  logic [1:0]  nc;
  logic        c_we, G_we, A_we, b_we, valid, err;
  logic [3:0]  c_addr, G_raddr;
  logic [2:0]  G_caddr, A_caddr;
  logic [1:0]  A_raddr, b_addr;
  logic [31:0] c_wdata, G_wdata, A_wdata, b_wdata;

  czono_loader #(.DATA_WIDTH(32), .NMAX(10), .NGMAX(5), .NCMAX(3)) dut (
    .clk_i(clk_tb), .rstn_i(rstn), .start(start), .s(s_if),
    .n(n), .ng(ng), .nc(nc),
    .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .G_we(G_we), .G_raddr(G_raddr), .G_caddr(G_caddr), .G_wdata(G_wdata),
    .A_we(A_we), .A_raddr(A_raddr), .A_caddr(A_caddr), .A_wdata(A_wdata),
    .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .valid(valid), .err(err)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor: shadow RAMs, write counts, write/valid timing.
  int cyc = 0;
  always @(posedge clk_tb) cyc <= cyc + 1;

  logic [31:0] tb_c [16];
  logic [31:0] tb_G [16][8];
  logic [31:0] tb_A [4][8];
  logic [31:0] tb_b [4];
  int  nwe_c, nwe_G, nwe_A, nwe_b, multi_we, bad_we, last_we, rise_cyc, nw;
  bit  clr = 1'b0;
  bit  hs_prev = 1'b0;
  bit  valid_prev = 1'b0;

  always @(negedge clk_tb) begin
    if (clr) begin
      for (int i = 0; i < 16; i++) begin
        tb_c[i] = 32'hdeadbeef;
        for (int j = 0; j < 8; j++) tb_G[i][j] = 32'hdeadbeef;
      end
      for (int i = 0; i < 4; i++) begin
        tb_b[i] = 32'hdeadbeef;
        for (int j = 0; j < 8; j++) tb_A[i][j] = 32'hdeadbeef;
      end
      nwe_c = 0; nwe_G = 0; nwe_A = 0; nwe_b = 0;
      multi_we = 0; bad_we = 0; last_we = -1; rise_cyc = -1;
    end
    nw = int'(c_we) + int'(G_we) + int'(A_we) + int'(b_we);
    if (nw > 1) multi_we++;
    if (nw > 0) begin
      if (!hs_prev) bad_we++;
      last_we = cyc;
    end
    if (c_we) begin tb_c[c_addr] = c_wdata; nwe_c++; end
    if (G_we) begin tb_G[G_raddr][G_caddr] = G_wdata; nwe_G++; end
    if (A_we) begin tb_A[A_raddr][A_caddr] = A_wdata; nwe_A++; end
    if (b_we) begin tb_b[b_addr] = b_wdata; nwe_b++; end
    if (valid && !valid_prev) rise_cyc = cyc;
    valid_prev = valid;
    hs_prev = s_if.s_valid && s_if.s_ready;
  end

  // Driver
  logic [31:0] stream[$];
  logic [31:0] t1 [13] = '{32'h00010302,
    32'h40a00000, 32'h3f000000,
    32'h3f000000, 32'h3f800000, 32'hbf000000, 32'h3f000000, 32'h3f000000, 32'h00000000,
    32'h3f000000, 32'h3f800000, 32'hbf000000,
    32'h3f800000};
  logic [31:0] t3 [7] = '{32'h00000202,
    32'h11110001, 32'h11110002,
    32'h22220001, 32'h22220002, 32'h22220003, 32'h22220004};
  logic [31:0] bad_hdr [3] = '{32'h0001010b, 32'h00000002, 32'h00040102};
  int hdr_cyc, lat1, lat2;

  task automatic do_clear();
    clr = 1'b1;
    @(posedge clk_tb);
    @(negedge clk_tb);
    #1 clr = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk_tb);
    #1 start = 1'b0;
  endtask

  task automatic push(input logic [31:0] w, input bit is_hdr);
    int t;
    t = 0;
    s_if.s_data  = w;
    s_if.s_valid = 1'b1;
    forever begin
      @(negedge clk_tb);
      if (s_if.s_ready) break;
      t++;
      if (t > 100) begin
        check("hs_timeout", 1, 0);
        break;
      end
    end
    if (is_hdr) hdr_cyc = cyc;
    @(posedge clk_tb);
    #1 s_if.s_valid = 1'b0;
  endtask

  // ck_mode: 0 no checksum word, 1 correct checksum, 2 checksum with bit 0 flipped
  task automatic run_load(input bit stall, input int ck_mode);
    logic [31:0] xs;
    int k;
    do_clear();
    do_start();
    xs = '0;
    for (int i = 0; i < stream.size(); i++) begin
      xs ^= stream[i];
      push(stream[i], i == 0);
      if (stall && (i < stream.size() - 1 || (CK == 1 && ck_mode != 0))) begin
        @(posedge clk_tb);
        #1;
      end
    end
    if (CK == 1 && ck_mode != 0) push((ck_mode == 2) ? (xs ^ 32'h1) : xs, 1'b0);
    k = 0;
    while (k < 60 && !(valid || err)) begin
      @(negedge clk_tb);
      k++;
    end
    repeat (3) @(negedge clk_tb);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ready"}, s_if.s_ready, 0);
    check({tag, "_we"}, {c_we, G_we, A_we, b_we}, 0);
    check({tag, "_addr"}, {c_addr, G_raddr, G_caddr, A_raddr, A_caddr, b_addr}, 0);
    check({tag, "_wdata"}, {c_wdata ^ G_wdata, A_wdata ^ b_wdata}, 0);
    check({tag, "_wdata_or"}, c_wdata | G_wdata | A_wdata | b_wdata, 0);
    check({tag, "_dims"}, {n, ng, nc}, 0);
    check({tag, "_valid_err"}, {valid, err}, 0);
  endtask

  task automatic verify_t1(input string tag);
    check({tag, "_valid"}, valid, 1);
    check({tag, "_err"}, err, 0);
    check({tag, "_ready_done"}, s_if.s_ready, 0);
    check({tag, "_dims"}, {n, ng, nc}, {4'd2, 3'd3, 2'd1});
    check({tag, "_counts"}, {nwe_c[7:0], nwe_G[7:0], nwe_A[7:0], nwe_b[7:0]}, 32'h02060301);
    check({tag, "_c0"}, tb_c[0], 32'h40a00000);
    check({tag, "_c1"}, tb_c[1], 32'h3f000000);
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 3; c++)
        check($sformatf("%s_G%0d%0d", tag, r, c), tb_G[r][c], t1[3 + r*3 + c]);
    for (int c = 0; c < 3; c++)
      check($sformatf("%s_A0%0d", tag, c), tb_A[0][c], t1[9 + c]);
    check({tag, "_b0"}, tb_b[0], 32'h3f800000);
    check({tag, "_one_we"}, multi_we, 0);
    check({tag, "_we_after_hs"}, bad_we, 0);
    check({tag, "_valid_after_we"}, rise_cyc, last_we + 1 + CK);
  endtask

  initial begin
    s_if.s_valid = 1'b0;
    s_if.s_data  = '0;
    #3 rstn = 1'b0;
    repeat (3) @(negedge clk_tb);
    check_zero("reset");
    rstn = 1'b1;
    @(negedge clk_tb);
    check("idle_ready", s_if.s_ready, 0);

    // Full load, s_valid held high
    stream = {};
    foreach (t1[i]) stream.push_back(t1[i]);
    run_load(1'b0, CK);
    verify_t1("load1");
    check("load1_lastwe_ofs", last_we - hdr_cyc, 13);
    lat1 = rise_cyc - hdr_cyc;
    check("load1_valid_ofs", lat1, 14 + CK);

    // Same load with s_valid toggling
    run_load(1'b1, CK);
    verify_t1("stall");
    check("stall_lastwe_ofs", last_we - hdr_cyc, 25);
    lat2 = rise_cyc - hdr_cyc;
    check("stall_delay", lat2 - lat1, 12 + CK);

    // nc = 0: A/B skipped
    stream = {};
    foreach (t3[i]) stream.push_back(t3[i]);
    run_load(1'b0, CK);
    check("nc0_valid", valid, 1);
    check("nc0_dims", {n, ng, nc}, {4'd2, 3'd2, 2'd0});
    check("nc0_ab_we", nwe_A + nwe_b, 0);
    check("nc0_counts", {nwe_c[7:0], nwe_G[7:0]}, 16'h0204);
    check("nc0_c1", tb_c[1], 32'h11110002);
    check("nc0_G01", tb_G[0][1], 32'h22220002);
    check("nc0_G11", tb_G[1][1], 32'h22220004);
    check("nc0_lastwe_ofs", last_we - hdr_cyc, 7);

    // Illegal headers
    for (int h = 0; h < 3; h++) begin
      stream = {};
      stream.push_back(bad_hdr[h]);
      run_load(1'b0, 0);
      check($sformatf("badhdr%0d_err", h), err, 1);
      check($sformatf("badhdr%0d_ready", h), s_if.s_ready, 0);
      check($sformatf("badhdr%0d_valid", h), valid, 0);
      check($sformatf("badhdr%0d_we", h), nwe_c + nwe_G + nwe_A + nwe_b, 0);
    end

    // Async reset during LD_G, then a fresh full load
    do_start();
    for (int i = 0; i < 5; i++) push(t1[i], i == 0);
    rstn = 1'b0;
    #2;
    check_zero("midrst");
    @(posedge clk_tb);
    @(negedge clk_tb);
    check("midrst_valid_held", valid, 0);
    rstn = 1'b1;
    stream = {};
    foreach (t1[i]) stream.push_back(t1[i]);
    run_load(1'b0, CK);
    verify_t1("reload");

`ifdef CZONO_LOADER_CHECKSUM_EN
    run_load(1'b0, 2);
    check("badck_err", err, 1);
    check("badck_valid", valid, 0);
    check("badck_writes", nwe_c + nwe_G + nwe_A + nwe_b, 12);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
